// File: rtl/f_pc_ctrl.sv
// f_pc_ctrl: fetch-stage PC register with exception/eret redirect, AdEL flag and fetch counter
module f_pc_ctrl #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
   parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [WIDTH-1:0] IM_LO      = 32'h0000_3000,
   parameter logic [WIDTH-1:0] IM_HI      = 32'h0000_6FFC,
   parameter int               CNT_W      = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_Req,
   input  logic             i_eret,
   input  logic [WIDTH-1:0] i_epc,
   input  logic [WIDTH-1:0] i_npc,
   output logic [WIDTH-1:0] or_pc,
   output logic             o_excAdEL,
   output logic             or_redirect,
   output logic [1:0]       or_src,
   output logic [CNT_W-1:0] or_fetch_cnt
);
   if (RESET_PC < IM_LO || RESET_PC > IM_HI || RESET_PC[1:0] != 2'b00 ||
       HANDLER_PC < IM_LO || HANDLER_PC > IM_HI || HANDLER_PC[1:0] != 2'b00) begin : g_bad_params
      $error("f_pc_ctrl: RESET_PC and HANDLER_PC must be word-aligned and inside [IM_LO, IM_HI]");
   end
   logic [WIDTH-1:0] pc_q = RESET_PC;
   logic [WIDTH-1:0] pc_d;
   logic             redirect_q, redirect_d;
   logic [1:0]       src_q, src_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // next PC: exception beats eret beats normal advance; a stall holds everything but drops redirect
   always_comb begin
      pc_d       = pc_q;
      redirect_d = 1'b0;
      src_d      = src_q;
      cnt_d      = cnt_q;
      if (i_Req) begin
         pc_d       = HANDLER_PC;
         redirect_d = 1'b1;
         src_d      = 2'b10;
      end else if (i_eret) begin
         pc_d       = i_epc;
         redirect_d = 1'b1;
         src_d      = 2'b11;
      end else if (i_en) begin
         pc_d  = i_npc;
         src_d = 2'b01;
         cnt_d = cnt_q + 1'b1;
      end
   end
   // state registers; reset overrides every other source
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q       <= RESET_PC;
         redirect_q <= 1'b0;
         src_q      <= 2'b00;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
      end
   end
   assign or_pc        = pc_q;
   assign or_redirect  = redirect_q;
   assign or_src       = src_q;
   assign or_fetch_cnt = cnt_q;
   assign o_excAdEL    = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);
endmodule

// File: tb/tb_f_pc_ctrl.sv
// tb_f_pc_ctrl: vector table plus scoreboard check of f_pc_ctrl (default and CNT_W=4 instances)
module tb_f_pc_ctrl;
   typedef struct {
      logic        rst, en, req, eret;
      logic [31:0] epc, npc;
      logic [31:0] pc;
      logic        adel, redir;
      logic [1:0]  src;
      logic [31:0] cnt;
      logic [3:0]  cnt4;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst, en, req, eret;
   logic [31:0] epc, npc;
   logic [31:0] pc, pc4;
   logic        adel, adel4, redir, redir4;
   logic [1:0]  src, src4;
   logic [31:0] cnt;
   logic [3:0]  cnt4;
   int          n_run = 0;
   int          n_fail = 0;
   vec_t        tbl[18];
   vec_t        sb[$];
   always #5 clk = ~clk;
   f_pc_ctrl dut (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_Req(req), .i_eret(eret), .i_epc(epc), .i_npc(npc),
      .or_pc(pc), .o_excAdEL(adel), .or_redirect(redir), .or_src(src), .or_fetch_cnt(cnt)
   );
   f_pc_ctrl #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_Req(req), .i_eret(eret), .i_epc(epc), .i_npc(npc),
      .or_pc(pc4), .o_excAdEL(adel4), .or_redirect(redir4), .or_src(src4), .or_fetch_cnt(cnt4)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      rst = v.rst; en = v.en; req = v.req; eret = v.eret; epc = v.epc; npc = v.npc;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".adel"}, {31'b0, adel}, {31'b0, e.adel});
      chk({tag, ".redir"}, {31'b0, redir}, {31'b0, e.redir});
      chk({tag, ".src"}, {30'b0, src}, {30'b0, e.src});
      chk({tag, ".cnt"}, cnt, e.cnt);
      chk({tag, ".cnt4"}, {28'b0, cnt4}, {28'b0, e.cnt4});
      chk({tag, ".pc4"}, pc4, e.pc);
   endtask
   initial begin
      vec_t v;
      //          rst  en   req  eret epc          npc          pc           adel redir src    cnt cnt4
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'h3000,    1'b0,1'b0,2'b00, 0,  0};
      tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h3004,    32'h3004,    1'b0,1'b0,2'b01, 1,  1};
      tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h3008,    32'h3008,    1'b0,1'b0,2'b01, 2,  2};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h5000,    32'h3008,    1'b0,1'b0,2'b01, 2,  2};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h5000,    32'h3008,    1'b0,1'b0,2'b01, 2,  2};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h5000,    32'h3008,    1'b0,1'b0,2'b01, 2,  2};
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,32'h3010,    32'h5000,    32'h4180,    1'b0,1'b1,2'b10, 2,  2};
      tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h3100,    32'h3100,    1'b0,1'b0,2'b01, 3,  3};
      tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,32'h3010,    32'h4184,    32'h3010,    1'b0,1'b1,2'b11, 3,  3};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,32'h3020,    32'h0,       32'h3020,    1'b0,1'b1,2'b11, 3,  3};
      tbl[10] = '{1'b0,1'b1,1'b1,1'b0,32'h0,       32'h3300,    32'h4180,    1'b0,1'b1,2'b10, 3,  3};
      tbl[11] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h3002,    32'h3002,    1'b1,1'b0,2'b01, 4,  4};
      tbl[12] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h2FFC,    32'h2FFC,    1'b1,1'b0,2'b01, 5,  5};
      tbl[13] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h7000,    32'h7000,    1'b1,1'b0,2'b01, 6,  6};
      tbl[14] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h6FFC,    32'h6FFC,    1'b0,1'b0,2'b01, 7,  7};
      tbl[15] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h3000,    32'h3000,    1'b0,1'b0,2'b01, 8,  8};
      tbl[16] = '{1'b0,1'b0,1'b0,1'b1,32'h7001,    32'h0,       32'h7001,    1'b1,1'b1,2'b11, 8,  8};
      tbl[17] = '{1'b1,1'b1,1'b1,1'b1,32'h3010,    32'h3400,    32'h3000,    1'b0,1'b0,2'b00, 0,  0};
      for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("v%0d", i));
      for (int k = 1; k <= 17; k++) begin
         v = '{1'b0,1'b1,1'b0,1'b0,32'h0,32'h3000 + 32'(4*k),32'h3000 + 32'(4*k),1'b0,1'b0,2'b01,32'(k),4'(k)};
         apply(v, $sformatf("wrap%0d", k));
      end
      v = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h5000,32'h3044,1'b0,1'b0,2'b01,17,1};
      apply(v, "stall");
      v = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h5000,32'h3000,1'b0,1'b0,2'b00,0,0};
      apply(v, "rst_stall");
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
